// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   uart_state_e   - frame FSM encoding (IDLE, START, DATA, PARITY, STOP)
//   PAR_EVEN/ODD   - parity-type select values
//   LINE_IDLE      - line level while idle and during the stop bit
//   START_BIT      - line level during the start bit
//   frame_parity() - parity bit for a word of up to MAX_DATA_WIDTH bits
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

  localparam int MAX_DATA_WIDTH = 9;

  // Narrower words are zero-extended by the caller; the extra zeros do not
  // change the XOR reduction.
  function automatic logic frame_parity(input logic [MAX_DATA_WIDTH-1:0] data,
                                        input logic                      par_typ);
    return (par_typ == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..CLKS_PER_BIT-1 while enabled and wraps.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   en   - advance the count this cycle
//   clr  - force the count back to zero (takes priority over en)
//   wrap - high in the last cycle of a bit period (count at CLKS_PER_BIT-1
//          while enabled); the owner advances its bit/state on this edge
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  // With CLKS_PER_BIT = 1 the count is always LAST, so every enabled cycle wraps.
  assign wrap = en && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: transmit-side UART framer. Takes a parallel word over a
// valid/ready handshake and sends start bit, DATA_WIDTH data bits LSB first,
// an optional parity bit and one stop bit, each held CLKS_PER_BIT clocks.
//
// Handshake: a word transfers on a rising edge where DATA_VALID && DATA_READY;
// P_DATA, PAR_EN and PAR_TYP are captured together on that edge. The source
// keeps all three stable until then. DATA_VALID while DATA_READY is low is
// ignored.
//
// Ports:
//   clk, rst    - clock (rising edge), asynchronous active-high reset
//   P_DATA      - word to send
//   DATA_VALID  - source offers P_DATA
//   DATA_READY  - block accepts a word this cycle
//   PAR_EN      - 1 inserts a parity bit
//   PAR_TYP     - 0 even, 1 odd
//   TX_OUT      - registered serial line, idle high
//   BUSY        - frame in progress (START..STOP)
//   fsm_state   - current frame state (uart_state_e encoding), for debug
//
// Build option UART_TX_HOLD_BUF_EN: adds a one-entry holding buffer so a word
// can be accepted during a frame and sent with no idle gap after the stop bit.
// Without it, DATA_READY is high only in IDLE.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic [2:0]            fsm_state
);

  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  uart_state_e           state, state_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [IW-1:0]         bit_idx, bit_idx_n;
  logic                  par_en_q, par_en_n;
  logic                  par_bit_q, par_bit_n;
  logic                  tx_q, tx_n;
  logic                  accept, take_input, wrap, in_par;

  // Parity is fixed at capture time so the frame is independent of later
  // input changes.
  assign in_par = frame_parity(MAX_DATA_WIDTH'(P_DATA), PAR_TYP);

`ifdef UART_TX_HOLD_BUF_EN
  logic                  hold_full, hold_par_en, hold_par_bit;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  take_hold, hold_load;

  assign DATA_READY = !hold_full;
`else
  assign DATA_READY = (state == IDLE);
`endif

  assign accept = DATA_VALID && DATA_READY;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .clr  (state == IDLE),
    .wrap (wrap)
  );

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_idx_n  = bit_idx;
    par_en_n   = par_en_q;
    par_bit_n  = par_bit_q;
    take_input = 1'b0;
`ifdef UART_TX_HOLD_BUF_EN
    take_hold  = 1'b0;
    hold_load  = 1'b0;
`endif

    case (state)
      IDLE:   if (accept) take_input = 1'b1;
      START:  if (wrap) begin
                state_n   = DATA;
                bit_idx_n = '0;
              end
      DATA:   if (wrap) begin
                shreg_n = shreg >> 1;
                if (bit_idx == LAST_BIT) state_n = par_en_q ? PARITY : STOP;
                else                     bit_idx_n = bit_idx + 1'b1;
              end
      PARITY: if (wrap) state_n = STOP;
      STOP:   if (wrap) begin
`ifdef UART_TX_HOLD_BUF_EN
                // A buffered word goes first; otherwise a word arriving on
                // the wrap edge itself starts straight away.
                if (hold_full)   take_hold  = 1'b1;
                else if (accept) take_input = 1'b1;
                else             state_n    = IDLE;
`else
                state_n = IDLE;
`endif
              end
      default: state_n = IDLE;
    endcase

    if (take_input) begin
      state_n   = START;
      shreg_n   = P_DATA;
      par_en_n  = PAR_EN;
      par_bit_n = in_par;
    end

`ifdef UART_TX_HOLD_BUF_EN
    if (take_hold) begin
      state_n   = START;
      shreg_n   = hold_data;
      par_en_n  = hold_par_en;
      par_bit_n = hold_par_bit;
    end
    // Any accepted word not started directly is parked in the buffer.
    hold_load = accept && !take_input;
`endif

    // Line level follows the state being entered so TX_OUT is a pure register.
    tx_n = LINE_IDLE;
    case (state_n)
      IDLE:    tx_n = LINE_IDLE;
      START:   tx_n = START_BIT;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par_bit_n;
      STOP:    tx_n = LINE_IDLE;
      default: tx_n = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_idx   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= LINE_IDLE;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_idx   <= bit_idx_n;
      par_en_q  <= par_en_n;
      par_bit_q <= par_bit_n;
      tx_q      <= tx_n;
    end
  end

`ifdef UART_TX_HOLD_BUF_EN
  // Load wins over drain on the same edge: the buffer stays full with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full    <= 1'b0;
      hold_data    <= '0;
      hold_par_en  <= 1'b0;
      hold_par_bit <= 1'b0;
    end else if (hold_load) begin
      hold_full    <= 1'b1;
      hold_data    <= P_DATA;
      hold_par_en  <= PAR_EN;
      hold_par_bit <= in_par;
    end else if (take_hold) begin
      hold_full    <= 1'b0;
    end
  end
`endif

  assign TX_OUT    = tx_q;
  assign BUSY      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame (DATA_WIDTH 8,
// CLKS_PER_BIT 4). Expected line sequences are hand-written strings in
// transmit order and expanded to one expected level per clock.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] P_DATA;
  logic          DATA_VALID;
  logic          DATA_READY;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          TX_OUT;
  logic          BUSY;
  logic [2:0]    fsm_state;

  int n_vec = 0;
  int n_err = 0;

  logic [0:0] exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .DATA_READY (DATA_READY),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .fsm_state  (fsm_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard helpers
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bits(input string s);
    for (int i = 0; i < s.len(); i++)
      for (int c = 0; c < CPB; c++)
        exp_q.push_back((s.getc(i) == "1") ? 1'b1 : 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"},    {31'd0, TX_OUT},     32'd1);
    check({tag, " busy"},  {31'd0, BUSY},       32'd0);
    check({tag, " ready"}, {31'd0, DATA_READY}, 32'd1);
    check({tag, " state"}, {29'd0, fsm_state},  32'(IDLE));
  endtask

  // Checks one clock per iteration, then steps to 1 time unit after the next edge.
  task automatic run_cycles(input int n, input string tag);
    logic e;
    for (int k = 0; k < n; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      check({tag, " tx"},   {31'd0, TX_OUT}, {31'd0, e});
      check({tag, " busy"}, {31'd0, BUSY},   32'd1);
      @(posedge clk); #1;
    end
  endtask

  // Driver: offer a word; returns 1 time unit after the handshake edge.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst        = 1'b1;
    P_DATA     = '0;
    DATA_VALID = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_idle("reset held");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("after reset");

    // 0xA5, even parity: parity bit 0
    push_bits("01010010101");
    send(8'hA5, 1'b1, PAR_EVEN);
    DATA_VALID = 1'b0;
    run_cycles(44, "a5_even");
    check_idle("a5_even end");

    // 0xA5, odd parity: parity bit 1
    push_bits("01010010111");
    send(8'hA5, 1'b1, PAR_ODD);
    DATA_VALID = 1'b0;
    run_cycles(44, "a5_odd");
    check_idle("a5_odd end");

    // 0x00 without parity; PAR_TYP must not matter
    push_bits("0000000001");
    send(8'h00, 1'b0, PAR_ODD);
    DATA_VALID = 1'b0;
    run_cycles(40, "00_nopar");
    check_idle("00_nopar end");

    // Reset during data bit 3 of 0xFF (cycles 16..19 of the frame)
    push_bits("01111");
    send(8'hFF, 1'b1, PAR_EVEN);
    DATA_VALID = 1'b0;
    run_cycles(18, "ff_pre_rst");
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("mid_rst tx",    {31'd0, TX_OUT}, 32'd1);
    check("mid_rst busy",  {31'd0, BUSY},   32'd0);
    check("mid_rst state", {29'd0, fsm_state}, 32'(IDLE));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("after mid_rst");
    @(posedge clk); #1;

    // 0x3C, odd parity after the abandoned frame
    push_bits("00011110011");
    send(8'h3C, 1'b1, PAR_ODD);
    DATA_VALID = 1'b0;
    run_cycles(44, "3c_odd");
    check_idle("3c_odd end");

    // Back-to-back 0x55 then 0x0F with DATA_VALID held, no parity
    push_bits("0101010101");
    push_bits("0111100001");
    send(8'h55, 1'b0, PAR_EVEN);
    P_DATA = 8'h0F;
`ifdef UART_TX_HOLD_BUF_EN
    check("b2b ready first cycle", {31'd0, DATA_READY}, 32'd1);
    run_cycles(1, "b2b f1");
    // 0x0F was buffered on that edge; later input changes must not leak in
    DATA_VALID = 1'b0;
    P_DATA     = 8'hAA;
    PAR_EN     = 1'b1;
    check("b2b ready after 2nd accept", {31'd0, DATA_READY}, 32'd0);
    run_cycles(38, "b2b f1");
    check("b2b ready before stop wrap", {31'd0, DATA_READY}, 32'd0);
    run_cycles(1, "b2b f1");
    check("b2b ready after drain", {31'd0, DATA_READY}, 32'd1);
    run_cycles(40, "b2b f2");
    check_idle("b2b end");
`else
    check("b2b ready during frame", {31'd0, DATA_READY}, 32'd0);
    run_cycles(40, "b2b f1");
    // exactly one idle-high cycle before the second word is taken
    check_idle("b2b gap");
    @(posedge clk); #1;
    DATA_VALID = 1'b0;
    P_DATA     = 8'hAA;
    check("b2b ready during f2", {31'd0, DATA_READY}, 32'd0);
    run_cycles(40, "b2b f2");
    check_idle("b2b end");
`endif

    check("exp_q drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
